// File: rtl/serializer_par.sv
// Parallel-to-serial converter with variable word length and a one-deep pending buffer.
// Words run back-to-back; busy_o reflects the pending slot being occupied.
module serializer_par #(
    parameter int DATA_W    = 16,
    parameter int MOD_W     = $clog2(DATA_W),
    parameter int MIN_LEN   = 3,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    localparam int LEN_W_MIN = $clog2(DATA_W + 1);
    localparam int LEN_W     = (MOD_W > LEN_W_MIN) ? MOD_W : LEN_W_MIN;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] act_sr_q, act_sr_d;
    logic [LEN_W-1:0]  act_cnt_q, act_cnt_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic [LEN_W-1:0]  pend_len_q, pend_len_d;
    logic              pend_full_q, pend_full_d;
    logic              ser_d, ser_val_d;

    logic [LEN_W-1:0]  in_len_raw;
    logic [LEN_W-1:0]  in_len;
    logic              in_ok;
    logic              accept;
    logic              last_bit;

    logic              load;
    logic [DATA_W-1:0] load_word;
    logic [LEN_W-1:0]  load_len;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] rest_bits(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    // A length field wider than the word is clamped so no bit beyond the word is ever sent.
    always_comb begin
        in_len_raw = LEN_W'(data_mod_i);
        if (data_mod_i == '0) begin
            in_len = LEN_W'(DATA_W);
        end else if (in_len_raw > LEN_W'(DATA_W)) begin
            in_len = LEN_W'(DATA_W);
        end else begin
            in_len = in_len_raw;
        end
    end

    assign in_ok    = (in_len >= LEN_W'(MIN_LEN));
    assign accept   = data_val_i && !pend_full_q && in_ok;
    assign last_bit = (act_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        act_sr_d    = act_sr_q;
        act_cnt_d   = act_cnt_q;
        pend_data_d = pend_data_q;
        pend_len_d  = pend_len_q;
        pend_full_d = pend_full_q;
        ser_d       = 1'b0;
        ser_val_d   = 1'b0;
        load        = 1'b0;
        load_word   = data_i;
        load_len    = in_len;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    ser_d     = first_bit(act_sr_q);
                    ser_val_d = 1'b1;
                    act_sr_d  = rest_bits(act_sr_q);
                    act_cnt_d = act_cnt_q - LEN_W'(1);
                    if (accept) begin
                        pend_data_d = data_i;
                        pend_len_d  = in_len;
                        pend_full_d = 1'b1;
                    end
                end else if (pend_full_q) begin
                    load        = 1'b1;
                    load_word   = pend_data_q;
                    load_len    = pend_len_q;
                    pend_full_d = 1'b0;
                end else if (accept) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The first bit leaves on the loading edge, so the counter holds bits still to come.
        if (load) begin
            state_d   = SHIFT;
            ser_d     = first_bit(load_word);
            ser_val_d = 1'b1;
            act_sr_d  = rest_bits(load_word);
            act_cnt_d = load_len - LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q        <= IDLE;
            act_sr_q       <= '0;
            act_cnt_q      <= '0;
            pend_data_q    <= '0;
            pend_len_q     <= '0;
            pend_full_q    <= 1'b0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            act_sr_q       <= act_sr_d;
            act_cnt_q      <= act_cnt_d;
            pend_data_q    <= pend_data_d;
            pend_len_q     <= pend_len_d;
            pend_full_q    <= pend_full_d;
            ser_data_o     <= ser_d;
            ser_data_val_o <= ser_val_d;
        end
    end

    assign busy_o = pend_full_q;

endmodule

// File: tb/tb_serializer_par.sv
// Directed bench for serializer_par: a 16-bit MSB-first instance and an 8-bit LSB-first instance.
module tb_serializer_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n;
    logic [15:0] d16;
    logic [3:0]  m16;
    logic        v16;
    logic        s16, sv16, b16;
    logic [7:0]  d8;
    logic [2:0]  m8;
    logic        v8;
    logic        s8, sv8, b8;

    int checks = 0;
    int errors = 0;

    serializer_par #(.DATA_W(16), .MSB_FIRST(1)) dut16 (
        .clk_i         (clk),
        .arst_n_i      (arst_n),
        .data_i        (d16),
        .data_mod_i    (m16),
        .data_val_i    (v16),
        .ser_data_o    (s16),
        .ser_data_val_o(sv16),
        .busy_o        (b16)
    );

    serializer_par #(.DATA_W(8), .MSB_FIRST(0)) dut8 (
        .clk_i         (clk),
        .arst_n_i      (arst_n),
        .data_i        (d8),
        .data_mod_i    (m8),
        .data_val_i    (v8),
        .ser_data_o    (s8),
        .ser_data_val_o(sv8),
        .busy_o        (b8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        d16 = '0; m16 = '0; v16 = 1'b0;
        d8  = '0; m8  = '0; v8  = 1'b0;
        #3;
        checks++;
        if ({s16, sv16, b16} !== 3'b000) begin
            errors++;
            $display("FAIL reset16: got ser=%b val=%b busy=%b, expected all 0", s16, sv16, b16);
        end
        checks++;
        if ({s8, sv8, b8} !== 3'b000) begin
            errors++;
            $display("FAIL reset8: got ser=%b val=%b busy=%b, expected all 0", s8, sv8, b8);
        end
        tick();
        tick();
        arst_n = 1'b1;
        tick();
        checks++;
        if ({s16, sv16, b16} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got ser=%b val=%b busy=%b, expected all 0", s16, sv16, b16);
        end
    endtask

    task automatic test_full_word();
        logic [15:0] exp;
        exp = 16'hA5F0;
        d16 = 16'hA5F0; m16 = 4'd0; v16 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            v16 = 1'b0;
            checks++;
            if (sv16 !== 1'b1 || s16 !== exp[15-i]) begin
                errors++;
                $display("FAIL full_word bit %0d: got val=%b bit=%b, expected val=1 bit=%b", i, sv16, s16, exp[15-i]);
            end
        end
        tick();
        checks++;
        if (sv16 !== 1'b0 || s16 !== 1'b0) begin
            errors++;
            $display("FAIL full_word_end: got val=%b bit=%b, expected 0 0", sv16, s16);
        end
    endtask

    task automatic test_min_len();
        d16 = 16'hFFFF; m16 = 4'd2; v16 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) m16 = 4'd1;
            else        v16 = 1'b0;
            checks++;
            if (sv16 !== 1'b0 || s16 !== 1'b0 || b16 !== 1'b0) begin
                errors++;
                $display("FAIL short_drop cycle %0d: got val=%b bit=%b busy=%b, expected 0 0 0", i, sv16, s16, b16);
            end
        end
        d16 = 16'hE000; m16 = 4'd3; v16 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            v16 = 1'b0;
            checks++;
            if (sv16 !== 1'b1 || s16 !== 1'b1) begin
                errors++;
                $display("FAIL min_len bit %0d: got val=%b bit=%b, expected 1 1", i, sv16, s16);
            end
        end
        tick();
        checks++;
        if (sv16 !== 1'b0) begin
            errors++;
            $display("FAIL min_len_end: got val=%b, expected 0", sv16);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_bits;
        logic [6:0] exp_busy;
        exp_bits = 7'b1001010;
        exp_busy = 7'b0111000;
        d16 = 16'h9000; m16 = 4'd4; v16 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) begin
                d16 = 16'h4000; m16 = 4'd3;
            end else begin
                v16 = 1'b0;
            end
            checks++;
            if (sv16 !== 1'b1 || s16 !== exp_bits[6-i] || b16 !== exp_busy[6-i]) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got val=%b bit=%b busy=%b, expected 1 %b %b",
                         i, sv16, s16, b16, exp_bits[6-i], exp_busy[6-i]);
            end
        end
        tick();
        checks++;
        if (sv16 !== 1'b0 || b16 !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_end: got val=%b busy=%b, expected 0 0", sv16, b16);
        end
    endtask

    task automatic test_busy_drop();
        logic [6:0] exp_bits;
        logic [6:0] exp_busy;
        exp_bits = 7'b1001010;
        exp_busy = 7'b0111000;
        d16 = 16'h9000; m16 = 4'd4; v16 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            case (i)
                0: begin d16 = 16'h4000; m16 = 4'd3; end
                1: begin d16 = 16'hFFFF; m16 = 4'd0; end
                3: v16 = 1'b0;
                default: ;
            endcase
            checks++;
            if (i < 7) begin
                if (sv16 !== 1'b1 || s16 !== exp_bits[6-i] || b16 !== exp_busy[6-i]) begin
                    errors++;
                    $display("FAIL busy_drop cycle %0d: got val=%b bit=%b busy=%b, expected 1 %b %b",
                             i, sv16, s16, b16, exp_bits[6-i], exp_busy[6-i]);
                end
            end else if (sv16 !== 1'b0 || s16 !== 1'b0 || b16 !== 1'b0) begin
                errors++;
                $display("FAIL busy_drop_tail cycle %0d: got val=%b bit=%b busy=%b, expected 0 0 0", i, sv16, s16, b16);
            end
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp4;
        logic [7:0] exp8;
        exp4 = 4'b1011;
        exp8 = 8'hC5;
        d8 = 8'h0B; m8 = 3'd4; v8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            v8 = 1'b0;
            checks++;
            if (sv8 !== 1'b1 || s8 !== exp4[i] || b8 !== 1'b0) begin
                errors++;
                $display("FAIL lsb_first bit %0d: got val=%b bit=%b busy=%b, expected 1 %b 0", i, sv8, s8, b8, exp4[i]);
            end
        end
        d8 = 8'hFF; m8 = 3'd2; v8 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            v8 = 1'b0;
            checks++;
            if (sv8 !== 1'b0 || s8 !== 1'b0) begin
                errors++;
                $display("FAIL lsb_short_drop cycle %0d: got val=%b bit=%b, expected 0 0", i, sv8, s8);
            end
        end
        d8 = 8'hC5; m8 = 3'd0; v8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            v8 = 1'b0;
            checks++;
            if (sv8 !== 1'b1 || s8 !== exp8[i]) begin
                errors++;
                $display("FAIL lsb_full bit %0d: got val=%b bit=%b, expected 1 %b", i, sv8, s8, exp8[i]);
            end
        end
        tick();
        checks++;
        if (sv8 !== 1'b0 || s8 !== 1'b0) begin
            errors++;
            $display("FAIL lsb_full_end: got val=%b bit=%b, expected 0 0", sv8, s8);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] exp;
        logic [2:0]  exp_new;
        exp     = 16'hA5F0;
        exp_new = 3'b100;
        d16 = 16'hA5F0; m16 = 4'd0; v16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                d16 = 16'hE000; m16 = 4'd3;
            end else begin
                v16 = 1'b0;
            end
            checks++;
            if (sv16 !== 1'b1 || s16 !== exp[15-i] || b16 !== (i >= 1)) begin
                errors++;
                $display("FAIL pre_reset bit %0d: got val=%b bit=%b busy=%b, expected 1 %b %b",
                         i, sv16, s16, b16, exp[15-i], (i >= 1));
            end
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if ({s16, sv16, b16} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got ser=%b val=%b busy=%b, expected all 0", s16, sv16, b16);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({s16, sv16, b16} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got ser=%b val=%b busy=%b, expected all 0", i, s16, sv16, b16);
            end
        end
        arst_n = 1'b1;
        d16 = 16'h8000; m16 = 4'd3; v16 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            v16 = 1'b0;
            checks++;
            if (i < 3) begin
                if (sv16 !== 1'b1 || s16 !== exp_new[2-i] || b16 !== 1'b0) begin
                    errors++;
                    $display("FAIL post_reset bit %0d: got val=%b bit=%b busy=%b, expected 1 %b 0",
                             i, sv16, s16, b16, exp_new[2-i]);
                end
            end else if (sv16 !== 1'b0 || s16 !== 1'b0 || b16 !== 1'b0) begin
                errors++;
                $display("FAIL no_resume cycle %0d: got val=%b bit=%b busy=%b, expected 0 0 0", i, sv16, s16, b16);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_min_len();
        test_back_to_back();
        test_busy_drop();
        test_lsb_first();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serializer_par.md
SERIALIZER_PAR -- requirements
Module: serializer_par

Interface
REQ-001 SHALL have parameter DATA_W, default 16: parallel word width, >= 4.
REQ-002 SHALL have parameter MOD_W, default $clog2(DATA_W): width of the length field.
REQ-003 SHALL have parameter MIN_LEN, default 3: minimum serialisable length; range 1..DATA_W.
REQ-004 SHALL have parameter MSB_FIRST, default 1: 1 = data_i[DATA_W-1] sent first; 0 = data_i[0] sent first.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port arst_n_i  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port data_i  input  DATA_W  parallel word.
REQ-008 SHALL have port data_mod_i  input  MOD_W  bit count; 0 encodes DATA_W.
REQ-009 SHALL have port data_val_i  input  1  data_i/data_mod_i valid this cycle.
REQ-010 SHALL have port ser_data_o  output  1  serial bit.
REQ-011 SHALL have port ser_data_val_o  output  1  ser_data_o valid.
REQ-012 SHALL have port busy_o  output  1  input not accepted this cycle.

Function
REQ-013 SHALL compute LEN = (data_mod_i == 0) ? DATA_W : data_mod_i.
REQ-014 SHALL accept a word on an edge where data_val_i=1, busy_o=0 and LEN >= MIN_LEN.
REQ-015 SHALL silently drop words with LEN < MIN_LEN in any state, with no change to state, outputs or buffers.
REQ-016 SHALL ignore data_val_i while busy_o=1; the word is lost, not queued.
REQ-017 SHALL hold one active word (shift register + remaining-bit counter) and one pending word (data + LEN + full flag).
REQ-018 SHALL implement states IDLE (no active word) and SHIFT (active word emitting).
REQ-019 SHALL, in IDLE, move an accepted word to active and enter SHIFT; its first bit appears on ser_data_o in the cycle after the accepting edge.
REQ-020 SHALL, in SHIFT, emit exactly LEN consecutive bits, one per cycle, with ser_data_val_o=1 for each; order per MSB_FIRST, starting at the end of the word selected by REQ-004.
REQ-021 SHALL, in SHIFT, store an accepted word in the pending buffer when it is empty.
REQ-022 SHALL, on the edge ending an active word's last bit, load the pending word into active if it is full (clearing the flag), else load a word accepted on that same edge, else go to IDLE; words are back-to-back with no idle cycle.
REQ-023 SHALL drive busy_o = pending full, registered, with no combinational path from inputs.
REQ-024 SHALL drive ser_data_o=0 whenever ser_data_val_o=0.
REQ-025 SHALL register ser_data_o and ser_data_val_o; no combinational input-to-output path.
REQ-026 SHALL never emit a bit beyond LEN; unused high/low bits of data_i are don't-care.

Reset
REQ-027 SHALL, on arst_n_i=0, immediately clear ser_data_o, ser_data_val_o, busy_o, the pending flag and the counter, and enter IDLE, regardless of transfer in progress.
REQ-028 SHALL discard partial words on reset; the first accept is possible on the first rising edge with arst_n_i=1.

Verification
REQ-029 SHALL cover: DATA_W=16, MSB_FIRST=1, data_i=16'hA5F0, mod=0, one pulse -> 16 valid cycles, bits 1010010111110000, starting one cycle after accept.
REQ-030 SHALL cover: mod=2, then mod=1 (MIN_LEN=3) -> no ser_data_val_o, busy_o stays 0; then mod=3, data_i=16'hE000 -> 111.
REQ-031 SHALL cover: word A (mod=4, 16'h9000) then B (mod=3, 16'h4000) one cycle later -> busy_o=1 from the cycle after B's accepting edge until A's last bit; output 1001 then 010 with ser_data_val_o continuously high for 7 cycles.
REQ-032 SHALL cover: third word C presented while busy_o=1 -> C never appears on output.
REQ-033 SHALL cover: MSB_FIRST=0, DATA_W=8, data_i=8'h0B, mod=4 -> bits 1,1,0,1.
REQ-034 SHALL cover: arst_n_i pulsed low mid-word (after 5 of 16 bits) with a pending word -> outputs 0 during reset, neither word resumes, new word accepted on the first edge after release.
